// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control bundle between the multicycle control FSM and its datapath.
// Latency: none, wiring only.
// Backpressure: none; Hold is the only stall input and is driven by the datapath side.
interface multicycle_control_if;
  logic [5:0]  Opcode;
  logic [5:0]  Funct;
  logic        Hold;
  logic        PC_write;
  logic        Branch;
  logic        PC_src;
  logic        Reg_write;
  logic        Mem_to_reg;
  logic        Reg_dst;
  logic        IorD;
  logic        Mem_write;
  logic        IR_write;
  logic        ALU_src_a;
  logic [1:0]  ALU_src_b;
  logic [2:0]  ALU_control;
  logic [3:0]  State;
  logic        Illegal_op;
  logic        Instr_done;
  logic [31:0] Instr_count;

  // Controller side: reads the instruction fields, drives every control line.
  modport master (
    input  Opcode, Funct, Hold,
    output PC_write, Branch, PC_src, Reg_write, Mem_to_reg, Reg_dst, IorD,
           Mem_write, IR_write, ALU_src_a, ALU_src_b, ALU_control, State,
           Illegal_op, Instr_done, Instr_count
  );

  // Datapath side: supplies the instruction fields, consumes the controls.
  modport slave (
    output Opcode, Funct, Hold,
    input  PC_write, Branch, PC_src, Reg_write, Mem_to_reg, Reg_dst, IorD,
           Mem_write, IR_write, ALU_src_a, ALU_src_b, ALU_control, State,
           Illegal_op, Instr_done, Instr_count
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM sequencing fetch/decode/execute/memory/writeback for the multicycle datapath.
// Latency: one state per Clock (lw 5, sw/R/I 4, beq 3, illegal 2 cycles); outputs decoded from State.
// Backpressure: Hold freezes State and forces write enables low. Macro CTRL_INSTR_COUNT_EN builds the Instr_count counter.
module multicycle_control #(
  parameter logic [2:0] ADD_CODE = 3'b010,
  parameter logic [2:0] SUB_CODE = 3'b110,
  parameter logic [2:0] AND_CODE = 3'b000,
  parameter logic [2:0] OR_CODE  = 3'b001,
  parameter logic [2:0] SLT_CODE = 3'b111
) (
  input logic Clock,
  input logic Reset,
  multicycle_control_if.master bus
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3, MEMRD = 4'd4,
    MEMWB = 4'd5, MEMWR = 4'd6, REX = 4'd7, RWB = 4'd8, BEQ = 4'd9,
    IEX = 4'd10, IWB = 4'd11
  } state_t;

  state_t     state, state_next;
  logic [5:0] op_lat;       // opcode captured in DECODE; later states use this copy
  logic       illegal;
  logic       set_illegal;
  logic       freeze;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic       pc_write, branch, pc_src, reg_write, mem_to_reg, reg_dst, iord;
  logic       mem_write, ir_write, alu_src_a, instr_done;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;

  // Hold has no effect in IDLE so the machine always leaves reset.
  assign freeze = bus.Hold && (state != IDLE);

  // Decode R-type funct into legality and ALU operation.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ADD_CODE;
    case (bus.Funct)
      FN_ADD:  funct_alu = ADD_CODE;
      FN_SUB:  funct_alu = SUB_CODE;
      FN_AND:  funct_alu = AND_CODE;
      FN_OR:   funct_alu = OR_CODE;
      FN_SLT:  funct_alu = SLT_CODE;
      default: funct_ok  = 1'b0;
    endcase
  end

  // Next-state selection and illegal-instruction detection.
  always_comb begin
    state_next  = state;
    set_illegal = 1'b0;
    case (state)
      IDLE:   state_next = FETCH;
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (bus.Opcode)
          OP_RTYPE: begin
            if (funct_ok) begin
              state_next = REX;
            end else begin
              state_next  = FETCH;
              set_illegal = 1'b1;
            end
          end
          OP_LW, OP_SW:              state_next = MEMADR;
          OP_BEQ:                    state_next = BEQ;
          OP_ADDI, OP_ANDI, OP_ORI:  state_next = IEX;
          default: begin
            state_next  = FETCH;
            set_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: state_next = (op_lat == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_next = MEMWB;
      REX:    state_next = RWB;
      IEX:    state_next = IWB;
      // Last states of each instruction and unused codes 12-15 all restart at FETCH.
      default: state_next = FETCH;
    endcase
    if (freeze) begin
      state_next  = state;
      set_illegal = 1'b0;
    end
  end

  // State register, opcode capture and sticky illegal flag.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      op_lat  <= 6'd0;
      illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (state == DECODE) op_lat <= bus.Opcode;
      if (set_illegal) illegal <= 1'b1;
    end
  end

  // Moore output decode; anything not set for a state stays 0.
  always_comb begin
    pc_write    = 1'b0;
    branch      = 1'b0;
    pc_src      = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'd0;
    alu_control = 3'd0;
    instr_done  = 1'b0;
    case (state)
      FETCH: begin
        ir_write    = 1'b1;
        alu_src_a   = 1'b1;
        alu_src_b   = 2'd1;
        alu_control = ADD_CODE;
        pc_write    = 1'b1;
      end
      DECODE: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'd2;
        alu_control = ADD_CODE;
      end
      MEMADR: begin
        alu_src_b   = 2'd2;
        alu_control = ADD_CODE;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      REX: alu_control = funct_alu;
      RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      BEQ: begin
        alu_control = SUB_CODE;
        branch      = 1'b1;
        pc_src      = 1'b1;
        instr_done  = 1'b1;
      end
      IEX: begin
        case (op_lat)
          OP_ANDI: begin alu_src_b = 2'd3; alu_control = AND_CODE; end
          OP_ORI:  begin alu_src_b = 2'd3; alu_control = OR_CODE;  end
          default: begin alu_src_b = 2'd2; alu_control = ADD_CODE; end
        endcase
      end
      IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.PC_write    = pc_write   & ~freeze;
  assign bus.Branch      = branch     & ~freeze;
  assign bus.Reg_write   = reg_write  & ~freeze;
  assign bus.Mem_write   = mem_write  & ~freeze;
  assign bus.IR_write    = ir_write   & ~freeze;
  assign bus.Instr_done  = instr_done & ~freeze;
  assign bus.PC_src      = pc_src;
  assign bus.Mem_to_reg  = mem_to_reg;
  assign bus.Reg_dst     = reg_dst;
  assign bus.IorD        = iord;
  assign bus.ALU_src_a   = alu_src_a;
  assign bus.ALU_src_b   = alu_src_b;
  assign bus.ALU_control = alu_control;
  assign bus.State       = state;
  assign bus.Illegal_op  = illegal;

`ifdef CTRL_INSTR_COUNT_EN
  logic [31:0] instr_count;

  // Retired-instruction counter; wraps modulo 2^32, illegal instructions never pulse done.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) instr_count <= 32'd0;
    else if (instr_done & ~freeze) instr_count <= instr_count + 32'd1;
  end

  assign bus.Instr_count = instr_count;
`else
  assign bus.Instr_count = 32'd0;
`endif
endmodule
